puzzle_seq_ctrl: RTL

Instruction sequencer for the 8-puzzle solver core. It owns the 6-bit program counter that addresses the combinational instruction ROM and latches the returned 16-bit op. It resolves JMP/JNZ internally using a zero/condition flag. All other ops are issued to the register/ALU datapath over a valid/ready handshake. It also provides start/done control and a retired-instruction counter to the top level.

---
 rtl/puzzle_seq_ctrl_if.sv | 22 ++
 rtl/puzzle_seq_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/puzzle_seq_ctrl_if.sv
`timescale 1ns/1ps
// Sequencer-side bus of the 8-puzzle solver core: instruction ROM port plus
// the valid/ready issue channel towards the register/ALU datapath.
interface puzzle_seq_ctrl_if;
   logic [5:0]  pc;
   logic [15:0] op_in;
   logic        dp_valid;
   logic [15:0] dp_op;
   logic        dp_ready;
   logic        dp_flag;
   logic        dp_flag_we;

   modport master (
      output pc, dp_valid, dp_op,
      input  op_in, dp_ready, dp_flag, dp_flag_we
   );

   modport slave (
      input  pc, dp_valid, dp_op,
      output op_in, dp_ready, dp_flag, dp_flag_we
   );
endinterface

// File: rtl/puzzle_seq_ctrl.sv
`timescale 1ns/1ps
// Instruction sequencer for the 8-puzzle solver: PC/IR, JMP/JNZ resolution, datapath issue.
// Optional macro SINGLE_STEP_EN adds step/step_wait so each fetch waits for a step pulse.
module puzzle_seq_ctrl #(
   parameter logic [4:0] OPC_JMP = 5'd30,
   parameter logic [4:0] OPC_JNZ = 5'd31,
   parameter int         CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SINGLE_STEP_EN
   input  logic             step,
   output logic             step_wait,
`endif
   puzzle_seq_ctrl_if.master bus,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_ISSUE, S_DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [5:0]       pc;
   logic [15:0]      ir;
   logic [15:0]      dp_op;
   logic             dp_valid;
   logic             flag;
   logic [CNT_W-1:0] cnt;
   logic             fetch_go;
   logic             is_jmp;
   logic             is_jnz;
   logic             halt;
   logic [5:0]       tgt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

`ifdef SINGLE_STEP_EN
   assign fetch_go = step;
`else
   assign fetch_go = 1'b1;
`endif

   // Only the opcode and target fields are decoded; other IR bits pass through untouched.
   assign tgt    = ir[5:0];
   assign is_jmp = (ir[15:11] == OPC_JMP);
   assign is_jnz = (ir[15:11] == OPC_JNZ);
   assign halt   = is_jmp && (tgt == pc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_nxt = S_FETCH;
         S_FETCH:        if (fetch_go) state_nxt = S_EXEC;
         S_EXEC: begin
            if (halt)                  state_nxt = S_DONE;
            else if (is_jmp || is_jnz) state_nxt = S_FETCH;
            else                       state_nxt = S_ISSUE;
         end
         S_ISSUE:        if (bus.dp_ready) state_nxt = S_FETCH;
         default:        state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state == S_FETCH) || (state == S_EXEC) || (state == S_ISSUE);
      done     = (state == S_DONE);
      dp_valid = (state == S_ISSUE);
`ifdef SINGLE_STEP_EN
      step_wait = (state == S_FETCH) && !step;
`endif
   end

   // Architectural state: pc, ir, issued op, condition flag and retire counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc    <= '0;
         ir    <= '0;
         dp_op <= '0;
         flag  <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  pc   <= '0;
                  flag <= 1'b0;
                  cnt  <= '0;
               end
            end
            S_FETCH: begin
               if (fetch_go) ir <= bus.op_in;
            end
            S_EXEC: begin
               if (is_jmp) begin
                  if (!halt) begin
                     pc  <= tgt;
                     cnt <= sat_inc(cnt);
                  end
               end else if (is_jnz) begin
                  pc  <= flag ? tgt : pc + 6'd1;
                  cnt <= sat_inc(cnt);
               end else begin
                  dp_op <= ir;
               end
            end
            S_ISSUE: begin
               if (bus.dp_ready) begin
                  if (bus.dp_flag_we) flag <= bus.dp_flag;
                  pc  <= pc + 6'd1;
                  cnt <= sat_inc(cnt);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.pc       = pc;
   assign bus.dp_op    = dp_op;
   assign bus.dp_valid = dp_valid;
   assign instr_cnt    = cnt;

endmodule
